// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: buffers ALU commands in a FIFO, drives the head onto the ALU and
// registers each result behind a valid/ready handshake, trapping divide-by-zero.
module alu_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [DW-1:0]            cmd_a,
   input  logic [DW-1:0]            cmd_b,
   output logic [1:0]               alu_operation,
   output logic [DW-1:0]            alu_operand1,
   output logic [DW-1:0]            alu_operand2,
   input  logic [DW-1:0]            alu_result,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DW-1:0]            res_data,
   output logic [1:0]               res_op,
   output logic                     res_dz,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [1:0]    op_mem [DEPTH];
   logic [DW-1:0] a_mem  [DEPTH];
   logic [DW-1:0] b_mem  [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, issue, empty, dz;
   assign empty     = count == '0;
   assign cmd_ready = count != (AW+1)'(DEPTH);
   assign push      = cmd_valid & cmd_ready;
   assign issue     = ~empty & (~res_valid | res_ready);
   assign alu_operation = empty ? '0 : op_mem[rd_ptr];
   assign alu_operand1  = empty ? '0 : a_mem[rd_ptr];
   assign alu_operand2  = empty ? '0 : b_mem[rd_ptr];
   assign dz = (alu_operation == 2'd3) && (alu_operand2 == '0);
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr] <= cmd_op;
         a_mem[wr_ptr]  <= cmd_a;
         b_mem[wr_ptr]  <= cmd_b;
      end
   end
   // power-of-two depth lets the pointers wrap naturally; count tells full from empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(issue);
         count  <= count + (AW+1)'(push) - (AW+1)'(issue);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         res_dz    <= 1'b0;
      end else if (issue) begin
         res_valid <= 1'b1;
         res_data  <= dz ? '1 : alu_result;
         res_op    <= alu_operation;
         res_dz    <= dz;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: scoreboard bench for alu_cmd_queue with a behavioural ALU attached.
module tb_alu_cmd_queue;
   logic       clk = 0;
   logic       rst_n = 0;
   logic       cmd_valid = 0, cmd_ready;
   logic [1:0] cmd_op = 0;
   logic [7:0] cmd_a = 0, cmd_b = 0;
   logic [1:0] alu_operation;
   logic [7:0] alu_operand1, alu_operand2, alu_result;
   logic       res_valid, res_ready = 0, res_dz;
   logic [7:0] res_data;
   logic [1:0] res_op;
   logic [2:0] count;
   int total = 0, bad = 0;
   logic [10:0] sb[$];

   alu_cmd_queue #(.DEPTH(4), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_operation(alu_operation), .alu_operand1(alu_operand1),
      .alu_operand2(alu_operand2), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_op(res_op), .res_dz(res_dz), .count(count)
   );

   always #5 clk = ~clk;

   // stand-in ALU; returns 0 on divide-by-zero so the queue's override is visible
   always_comb begin
      logic [15:0] p;
      p = alu_operand1 * alu_operand2;
      alu_result = alu_operation == 2'd0 ? alu_operand1 + alu_operand2 :
                   alu_operation == 2'd1 ? alu_operand1 - alu_operand2 :
                   alu_operation == 2'd2 ? p[7:0] :
                   alu_operand2 == 8'd0  ? 8'h00 : alu_operand1 / alu_operand2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = {8'd0, a} * {8'd0, b};
      case (op)
         2'd0: return {1'b0, op, 8'(a + b)};
         2'd1: return {1'b0, op, 8'(a - b)};
         2'd2: return {1'b0, op, p[7:0]};
         default: return b == 0 ? {1'b1, op, 8'hFF} : {1'b0, op, 8'(a / b)};
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid && res_ready) begin
            if (sb.size() == 0) check("spurious_result", 1, 0);
            else begin
               logic [10:0] e;
               e = sb.pop_front();
               check("res_data", res_data, e[7:0]);
               check("res_op", res_op, e[9:8]);
               check("res_dz", res_dz, e[10]);
               check("res_no_x", $isunknown({res_data, res_op, res_dz}), 0);
            end
         end
         if (cmd_valid && cmd_ready) sb.push_back(model(cmd_op, cmd_a, cmd_b));
      end
   end

   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      bit ok = 0;
      cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk); #1;
      end
      if (!ok) check("send_timeout", 0, 1);
      cmd_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && !(count == 0 && !res_valid); i++) begin
         @(posedge clk); #1;
      end
      check("drain_done", {31'd0, count == 0 && !res_valid}, 1);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", count, 0);
      check("rst_valid", res_valid, 0);
      check("rst_data", res_data, 0);
      check("rst_op_dz", {res_op, res_dz}, 0);
      check("rst_alu", {alu_operation, alu_operand1, alu_operand2}, 0);
      rst_n = 1;
      check("rst_ready", cmd_ready, 1);
      res_ready = 1;
      // 1: latency
      send(2'd0, 8'd2, 8'd2);
      check("lat_not_yet", res_valid, 0);
      check("lat_count1", count, 1);
      check("alu_head", {alu_operation, alu_operand1, alu_operand2}, {2'd0, 8'd2, 8'd2});
      @(posedge clk); #1;
      check("lat_valid", res_valid, 1);
      check("lat_data", res_data, 8'h04);
      check("lat_count0", count, 0);
      drain();
      // 2: back-to-back, one result per cycle
      send(2'd1, 8'd2, 8'd3);
      send(2'd2, 8'd16, 8'd17);
      send(2'd3, 8'd200, 8'd7);
      repeat (2) begin @(posedge clk); #1; end
      check("b2b_all_out", sb.size(), 0);
      check("b2b_valid_low", res_valid, 0);
      // 3: divide by zero then recover
      send(2'd3, 8'd9, 8'd0);
      @(posedge clk); #1;
      check("dz_data", res_data, 8'hFF);
      check("dz_flag", res_dz, 1);
      send(2'd0, 8'd1, 8'd1);
      @(posedge clk); #1;
      check("dz_clear", {res_dz, res_data}, {1'b0, 8'h02});
      drain();
      // 4: back-pressure fills the queue
      res_ready = 0;
      send(2'd0, 8'd10, 8'd20);
      send(2'd1, 8'd50, 8'd60);
      send(2'd2, 8'd3, 8'd5);
      send(2'd3, 8'd100, 8'd9);
      send(2'd3, 8'd1, 8'd0);
      check("full_count", count, 4);
      check("full_ready", cmd_ready, 0);
      check("full_resv", res_valid, 1);
      cmd_valid = 1; cmd_op = 2'd0; cmd_a = 8'd7; cmd_b = 8'd7;
      repeat (3) begin @(posedge clk); #1; end
      check("sixth_refused", count, 4);
      check("hold_data", res_data, 8'h1E);
      cmd_valid = 0;
      res_ready = 1;
      drain();
      // 5: steady push+issue at COUNT=2 across pointer wrap
      res_ready = 0;
      send(2'd0, 8'd1, 8'd2);
      send(2'd0, 8'd3, 8'd4);
      send(2'd0, 8'd5, 8'd6);
      check("pre_count2", count, 2);
      res_ready = 1;
      for (int i = 0; i < 9; i++) begin
         send(2'(i), 8'(i * 37 + 11), 8'(i * 13 + 1));
         check("steady_count2", count, 2);
      end
      drain();
      // 6: reset mid-stream
      res_ready = 0;
      send(2'd0, 8'd1, 8'd1);
      send(2'd1, 8'd9, 8'd4);
      send(2'd2, 8'd7, 8'd7);
      send(2'd3, 8'd8, 8'd2);
      check("pre_rst_count", count, 3);
      #3 rst_n = 0;
      #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_data", res_data, 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1;
      check("post_rst_ready", cmd_ready, 1);
      res_ready = 1;
      send(2'd0, 8'd3, 8'd4);
      @(posedge clk); #1;
      check("post_rst_data", res_data, 8'h07);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
